// File: rtl/stream_decimate_axis_stall_detector_pkg.sv
// Shared types and constants for the AXI-Stream stall detector and its
// per-channel stall FSM.
package stream_decimate_axis_stall_detector_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    BLOCKED = 2'd2
  } stall_state_e;

  localparam int CH_IN  = 0;
  localparam int CH_OUT = 1;
  localparam int NUM_CH = 2;

  // Event counter add that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'd0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/stream_decimate_stall_chan.sv
// One channel's RUN/STALL/BLOCKED tracker with its consecutive-stall counter.
// The state register doubles as the debug view and the live block source.
module stream_decimate_stall_chan
  import stream_decimate_axis_stall_detector_pkg::*;
#(
  parameter int STALL_THRESH = 1024,
  parameter int CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_i,
  input  logic             idle_i,
  output stall_state_e     state_o,
  output logic [CNT_W-1:0] cnt_d_o,
  output logic             enter_o
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(STALL_THRESH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  stall_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (idle_i) begin
      state_d = RUN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (stall_i) begin
            state_d = STALL;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = '0;
          end
        end
        STALL: begin
          if (!stall_i) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            if (cnt_q == THRESH_M1) state_d = BLOCKED;
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        BLOCKED: begin
          if (!stall_i) begin
            state_d = RUN;
            cnt_d   = '0;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;
  assign cnt_d_o = cnt_d;
  // Entry is only possible from STALL; idle suppresses it via state_d.
  assign enter_o = (state_q != BLOCKED) && (state_d == BLOCKED);

endmodule

// File: rtl/stream_decimate_axis_stall_detector.sv
// Passive stall/deadlock observer for the input and output AXI-Stream sides
// of a decimator: live block flags plus sticky, peak and event statistics.
module stream_decimate_axis_stall_detector
  import stream_decimate_axis_stall_detector_pkg::*;
#(
  parameter int STALL_THRESH = 1024,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             s_tvalid,
  input  logic             s_tready,
  input  logic             m_tvalid,
  input  logic             m_tready,
  input  logic             inst_idle,
  input  logic             clear,
  output logic [1:0]       axis_block_sigs,
  output logic [1:0]       block_sticky,
  output logic [CNT_W-1:0] peak_stall,
  output logic [7:0]       event_count
);

  // Handshakes are only observed: a beat moves when tvalid & tready are both
  // high at a rising edge. The input side stalls when the consumer is ready
  // but no data is offered (starved); the output side stalls when data is
  // offered but the downstream is not ready (backpressured).
  logic [NUM_CH-1:0] stall;
  assign stall[CH_IN]  = s_tready & ~s_tvalid;
  assign stall[CH_OUT] = m_tvalid & ~m_tready;

  // Assert immediately, release two edges after reset returns high.
  logic [1:0] rst_sync_q;
  logic       rst_n;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  stall_state_e      chan_state [NUM_CH];
  logic [CNT_W-1:0]  chan_cnt_d [NUM_CH];
  logic [NUM_CH-1:0] enter;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    stream_decimate_stall_chan #(
      .STALL_THRESH (STALL_THRESH),
      .CNT_W        (CNT_W)
    ) u_chan (
      .clk_i   (clock),
      .rst_ni  (rst_n),
      .stall_i (stall[g]),
      .idle_i  (inst_idle),
      .state_o (chan_state[g]),
      .cnt_d_o (chan_cnt_d[g]),
      .enter_o (enter[g])
    );
    assign axis_block_sigs[g] = (chan_state[g] == BLOCKED);
  end

  logic [1:0]       sticky_q, sticky_d;
  logic [CNT_W-1:0] peak_q, peak_d, peak_max;
  logic [7:0]       event_q, event_d;

  // Peak tracks the post-update counters so it never trails a live run.
  always_comb begin
    peak_max = peak_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (chan_cnt_d[i] > peak_max) peak_max = chan_cnt_d[i];
    end
    if (clear) begin
      sticky_d = '0;
      peak_d   = '0;
      event_d  = '0;
    end else begin
      sticky_d = sticky_q | enter;
      peak_d   = peak_max;
      event_d  = sat_add8(event_q, 2'(enter[0]) + 2'(enter[1]));
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= '0;
      peak_q   <= '0;
      event_q  <= '0;
    end else begin
      sticky_q <= sticky_d;
      peak_q   <= peak_d;
      event_q  <= event_d;
    end
  end

  assign block_sticky = sticky_q;
  assign peak_stall   = peak_q;
  assign event_count  = event_q;

endmodule

// File: tb/tb_stream_decimate_axis_stall_detector.sv
// Bench for the stall detector: directed scenarios plus random traffic,
// checked every cycle against a run-length reference model.
module tb_stream_decimate_axis_stall_detector;

  localparam int THRESH = 4;
  localparam int CW     = 16;
  localparam int EW     = 2 + 2 + CW + 8;

  logic          clock;
  logic          reset;
  logic          s_tvalid, s_tready, m_tvalid, m_tready;
  logic          inst_idle, clear;
  logic [1:0]    axis_block_sigs, block_sticky;
  logic [CW-1:0] peak_stall;
  logic [7:0]    event_count;

  stream_decimate_axis_stall_detector #(
    .STALL_THRESH (THRESH),
    .CNT_W        (CW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .s_tvalid        (s_tvalid),
    .s_tready        (s_tready),
    .m_tvalid        (m_tvalid),
    .m_tready        (m_tready),
    .inst_idle       (inst_idle),
    .clear           (clear),
    .axis_block_sigs (axis_block_sigs),
    .block_sticky    (block_sticky),
    .peak_stall      (peak_stall),
    .event_count     (event_count)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard and reference model
  int n_checks = 0;
  int n_pass   = 0;
  logic [EW-1:0] exp_q[$];

  int         run_m [2];
  int         peak_m;
  int         ev_m;
  logic [1:0] sticky_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    run_m[0] = 0;
    run_m[1] = 0;
    peak_m   = 0;
    ev_m     = 0;
    sticky_m = 2'b00;
  endtask

  // A channel is blocked once its unbroken stall run reaches THRESH.
  task automatic model_step(input logic st0, input logic st1, input logic idle,
                            input logic clr, output logic [EW-1:0] e);
    logic [1:0] ent;
    logic [1:0] blk;
    int         cnt;
    ent = 2'b00;
    for (int ch = 0; ch < 2; ch++) begin
      if (idle || !(ch == 0 ? st0 : st1)) begin
        run_m[ch] = 0;
      end else begin
        run_m[ch]++;
        if (run_m[ch] == THRESH) ent[ch] = 1'b1;
      end
    end
    if (clr) begin
      sticky_m = 2'b00;
      peak_m   = 0;
      ev_m     = 0;
    end else begin
      sticky_m = sticky_m | ent;
      ev_m     = ev_m + int'(ent[0]) + int'(ent[1]);
      if (ev_m > 255) ev_m = 255;
      for (int ch = 0; ch < 2; ch++) begin
        cnt = (run_m[ch] > 65535) ? 65535 : run_m[ch];
        if (cnt > peak_m) peak_m = cnt;
      end
    end
    blk = {run_m[1] >= THRESH, run_m[0] >= THRESH};
    e = {blk, sticky_m, CW'(peak_m), 8'(ev_m)};
  endtask

  // driver: apply one cycle of inputs, then compare all outputs after the edge
  task automatic step(input logic sv, input logic sr, input logic mv, input logic mr,
                      input logic idle, input logic clr);
    logic [EW-1:0] e;
    s_tvalid  = sv;
    s_tready  = sr;
    m_tvalid  = mv;
    m_tready  = mr;
    inst_idle = idle;
    clear     = clr;
    model_step(sr & ~sv, mv & ~mr, idle, clr, e);
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    chk("block", 32'(axis_block_sigs), 32'(e[EW-1 -: 2]));
    chk("sticky", 32'(block_sticky), 32'(e[EW-3 -: 2]));
    chk("peak", 32'(peak_stall), 32'(e[EW-5 -: CW]));
    chk("event", 32'(event_count), 32'(e[7:0]));
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic both_stall(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 1, 0, 0, 0);
  endtask

  task automatic drive_zero();
    s_tvalid  = 1'b0;
    s_tready  = 1'b0;
    m_tvalid  = 1'b0;
    m_tready  = 1'b0;
    inst_idle = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic release_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    logic sv, sr, mv, mr, idl, clr;
    drive_zero();
    reset = 1'b1;
    model_reset();
    #3 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_block", 32'(axis_block_sigs), 32'h0);
    chk("rst_sticky", 32'(block_sticky), 32'h0);
    chk("rst_peak", 32'(peak_stall), 32'h0);
    chk("rst_event", 32'(event_count), 32'h0);
    release_reset();

    // output side backpressured for six cycles
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0, 0);
    quiet(2);
    chk("bp6_event", 32'(event_count), 32'd1);
    chk("bp6_peak", 32'(peak_stall), 32'd6);
    chk("bp6_sticky", 32'(block_sticky), 32'b10);
    chk("bp6_block_off", 32'(axis_block_sigs), 32'b00);

    // short starvation runs broken by one data beat
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
    quiet(1);
    chk("starve_block", 32'(axis_block_sigs), 32'b00);
    chk("starve_peak", 32'(peak_stall), 32'd3);
    chk("starve_event", 32'(event_count), 32'd0);

    // both sides stalled together
    step(0, 0, 0, 0, 0, 1);
    both_stall(4);
    chk("both_block", 32'(axis_block_sigs), 32'b11);
    both_stall(1);
    quiet(1);
    chk("both_event", 32'(event_count), 32'd2);

    // idle pulse while blocked
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0);
    chk("idle_drop", 32'(axis_block_sigs), 32'b00);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);
    chk("idle_still_low", 32'(axis_block_sigs), 32'b00);
    step(0, 0, 1, 0, 0, 0);
    chk("idle_reassert", 32'(axis_block_sigs), 32'b10);
    chk("idle_event", 32'(event_count), 32'd2);
    quiet(1);

    // random traffic biased toward stalls
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) begin sv = 1'b0; sr = 1'b1; end
      else begin sv = 1'($urandom); sr = 1'($urandom); end
      if ($urandom_range(0, 3) != 0) begin mv = 1'b1; mr = 1'b0; end
      else begin mv = 1'($urandom); mr = 1'($urandom); end
      idl = ($urandom_range(0, 39) == 0);
      clr = ($urandom_range(0, 39) == 0);
      step(sv, sr, mv, mr, idl, clr);
    end
    quiet(1);

    // event counter saturation
    step(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 127; k++) begin
      both_stall(4);
      quiet(1);
    end
    chk("sat_254", 32'(event_count), 32'd254);
    both_stall(4);
    chk("sat_255", 32'(event_count), 32'd255);
    both_stall(1);
    step(0, 1, 1, 0, 0, 1);
    chk("clr_sticky", 32'(block_sticky), 32'b00);
    chk("clr_peak", 32'(peak_stall), 32'd0);
    chk("clr_event", 32'(event_count), 32'd0);
    chk("clr_block_kept", 32'(axis_block_sigs), 32'b11);
    quiet(1);

    // clear on the very cycle both channels enter BLOCKED
    both_stall(3);
    step(0, 1, 1, 0, 0, 1);
    chk("clr_entry_block", 32'(axis_block_sigs), 32'b11);
    chk("clr_entry_sticky", 32'(block_sticky), 32'b00);
    chk("clr_entry_event", 32'(event_count), 32'd0);
    both_stall(2);

    // reset in the middle of a blocked run
    #2 reset = 1'b0;
    #1;
    chk("midrst_block", 32'(axis_block_sigs), 32'h0);
    chk("midrst_sticky", 32'(block_sticky), 32'h0);
    chk("midrst_peak", 32'(peak_stall), 32'h0);
    chk("midrst_event", 32'(event_count), 32'h0);
    drive_zero();
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    release_reset();
    both_stall(3);
    chk("post_rst_noblock", 32'(axis_block_sigs), 32'b00);
    both_stall(1);
    chk("post_rst_event", 32'(event_count), 32'd2);
    quiet(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
